laplacian_window_gen: RTL and testbench

Upstream feeder for the Conv1 Laplacian stage. Accepts a raster-order stream of 4-bit pixels and builds the 5-tap cross neighbourhood (north, west, center, east, south) for every interior pixel using two line buffers plus a tap register. It presents the taps as registered outputs with a valid strobe. Only interior centers (no image border) produce windows, so no padding logic is needed.

---
 rtl/laplacian_window_gen.sv | 89 ++++++++
 tb/tb_laplacian_window_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/laplacian_window_gen.sv
// Builds the 5-tap cross window (N/W/C/E/S) for interior pixels of a raster stream.
// Latency: taps visible one cycle after the south pixel is accepted; never stalls upstream.
module laplacian_window_gen #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int PIX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   input  logic             pix_sof,
   output logic [PIX_W-1:0] north,
   output logic [PIX_W-1:0] west,
   output logic [PIX_W-1:0] center,
   output logic [PIX_W-1:0] east,
   output logic [PIX_W-1:0] south,
   output logic             win_valid,
   output logic             frame_done
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int HIST  = 2 * IMG_W;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0] col, curCol;
   logic [ROW_W-1:0] row, curRow;
   logic             isInterior, isLast;
   // hist[k] holds the pixel accepted k+1 cycles-of-acceptance ago
   logic [PIX_W-1:0] hist [HIST];

   // A qualified sof overrides whatever position the counters hold
   always_comb begin
      curCol     = pix_sof ? '0 : col;
      curRow     = pix_sof ? '0 : row;
      isInterior = (curRow >= ROW_W'(2)) && (curCol >= COL_W'(1)) &&
                   (curCol <= COL_W'(IMG_W - 2));
      isLast     = (curRow == LAST_ROW) && (curCol == LAST_COL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (pix_valid) begin
         if (curCol == LAST_COL) begin
            col <= '0;
            row <= (curRow == LAST_ROW) ? '0 : curRow + 1'b1;
         end else begin
            col <= curCol + 1'b1;
            row <= curRow;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pix_valid) begin
         hist[0] <= pix_in;
         for (int i = 1; i < HIST; i++) begin
            hist[i] <= hist[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         north      <= '0;
         west       <= '0;
         center     <= '0;
         east       <= '0;
         south      <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= pix_valid && isInterior;
         frame_done <= pix_valid && isLast;
         if (pix_valid && isInterior) begin
            south  <= pix_in;
            east   <= hist[IMG_W-2];
            center <= hist[IMG_W-1];
            west   <= hist[IMG_W];
            north  <= hist[2*IMG_W-1];
         end
      end
   end

endmodule

// File: tb/tb_laplacian_window_gen.sv
// Directed and random stimulus on a 4x4 and an 8x3 instance, checked against an image-array model.
module tb_laplacian_window_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [3:0] pixA, nA, wA, cA, eA, sA;
   logic       vldA, sofA, wvA, fdA;
   logic [3:0] pixB, nB, wB, cB, eB, sB;
   logic       vldB, sofB, wvB, fdB;

   laplacian_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(4)) dutA (
      .clk(clk), .rst(rst), .pix_in(pixA), .pix_valid(vldA), .pix_sof(sofA),
      .north(nA), .west(wA), .center(cA), .east(eA), .south(sA),
      .win_valid(wvA), .frame_done(fdA));

   laplacian_window_gen #(.IMG_W(8), .IMG_H(3), .PIX_W(4)) dutB (
      .clk(clk), .rst(rst), .pix_in(pixB), .pix_valid(vldB), .pix_sof(sofB),
      .north(nB), .west(wB), .center(cB), .east(eB), .south(sB),
      .win_valid(wvB), .frame_done(fdB));

   int testCnt = 0;
   int failCnt = 0;

   // Reference model: full image array indexed by (row, col)
   int          mW, mH, mR, mC;
   logic [3:0]  img [8][8];
   logic [19:0] expTaps;
   logic        expWv, expFd;
   bit          useB;
   logic [19:0] winLog [$];
   int          fdCnt, run, maxRun;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelAccept(input logic [3:0] p, input bit sof);
      if (sof) begin
         mR = 0;
         mC = 0;
      end
      img[mR][mC] = p;
      expFd = (mR == mH - 1) && (mC == mW - 1);
      expWv = (mR >= 2) && (mC >= 1) && (mC <= mW - 2);
      if (expWv)
         expTaps = {img[mR-2][mC], img[mR-1][mC-1], img[mR-1][mC], img[mR-1][mC+1], p};
      mC++;
      if (mC == mW) begin
         mC = 0;
         mR++;
         if (mR == mH) mR = 0;
      end
   endtask

   task automatic modelReset();
      mR = 0;
      mC = 0;
      expTaps = '0;
      expWv = 1'b0;
      expFd = 1'b0;
   endtask

   task automatic step(input logic [3:0] p, input bit v, input bit sof);
      logic [19:0] taps;
      logic        wv, fd;
      if (useB) begin pixB = p; vldB = v; sofB = sof; end
      else      begin pixA = p; vldA = v; sofA = sof; end
      @(posedge clk);
      if (v) modelAccept(p, sof);
      else begin expWv = 1'b0; expFd = 1'b0; end
      #1;
      taps = useB ? {nB, wB, cB, eB, sB} : {nA, wA, cA, eA, sA};
      wv   = useB ? wvB : wvA;
      fd   = useB ? fdB : fdA;
      chk("win_valid", 32'(wv), 32'(expWv));
      chk("frame_done", 32'(fd), 32'(expFd));
      chk("taps", 32'(taps), 32'(expTaps));
      if (wv) begin
         winLog.push_back(taps);
         run++;
         if (run > maxRun) maxRun = run;
      end else begin
         run = 0;
      end
      if (fd) fdCnt++;
   endtask

   // kind 0: pixel = index, kind 1: pixel = 15 - index; stall inserts an idle cycle with junk inputs
   task automatic sendFrame(input bit kind, input bit stall);
      for (int i = 0; i < 16; i++) begin
         if (stall) step(4'($urandom), 1'b0, 1'($urandom));
         step(kind ? 4'(15 - i) : 4'(i), 1'b1, i == 0);
      end
   endtask

   task automatic clearLog();
      winLog.delete();
      fdCnt = 0;
      run = 0;
      maxRun = 0;
   endtask

   initial begin
      rst = 1'b1;
      pixA = '0; vldA = 1'b0; sofA = 1'b0;
      pixB = '0; vldB = 1'b0; sofB = 1'b0;
      useB = 1'b0;
      mW = 4; mH = 4;
      modelReset();
      clearLog();
      #12;
      chk("rst_taps", 32'({nA, wA, cA, eA, sA}), 32'h0);
      chk("rst_wv", 32'(wvA), 32'h0);
      chk("rst_fd", 32'(fdA), 32'h0);
      rst = 1'b0;

      // Continuous 4x4 frame
      sendFrame(1'b0, 1'b0);
      step(4'h0, 1'b0, 1'b0);
      chk("t1_count", winLog.size(), 4);
      chk("t1_win0", 32'(winLog[0]), 32'h14569);
      chk("t1_win1", 32'(winLog[1]), 32'h2567A);
      chk("t1_win2", 32'(winLog[2]), 32'h589AD);
      chk("t1_win3", 32'(winLog[3]), 32'h69ABE);
      chk("t1_fd", fdCnt, 1);

      // Same frame with a stall before every pixel
      clearLog();
      sendFrame(1'b0, 1'b1);
      chk("t2_count", winLog.size(), 4);
      chk("t2_win0", 32'(winLog[0]), 32'h14569);
      chk("t2_win3", 32'(winLog[3]), 32'h69ABE);
      chk("t2_fd", fdCnt, 1);

      // Back-to-back frames, second inverted
      clearLog();
      sendFrame(1'b0, 1'b0);
      sendFrame(1'b1, 1'b0);
      chk("t3_count", winLog.size(), 8);
      chk("t3_win4", 32'(winLog[4]), 32'hEBA96);
      chk("t3_fd", fdCnt, 2);

      // Abort after 6 pixels with a fresh sof
      clearLog();
      for (int i = 0; i < 6; i++) step(4'(i), 1'b1, i == 0);
      sendFrame(1'b0, 1'b0);
      chk("t4_count", winLog.size(), 4);
      chk("t4_win0", 32'(winLog[0]), 32'h14569);
      chk("t4_fd", fdCnt, 1);

      // Async reset while a window is valid, then a frame without sof
      for (int i = 0; i < 10; i++) step(4'(i), 1'b1, i == 0);
      chk("t5_wv_before", 32'(wvA), 32'h1);
      vldA = 1'b0;
      rst = 1'b1;
      #1;
      chk("t5_rst_taps", 32'({nA, wA, cA, eA, sA}), 32'h0);
      chk("t5_rst_wv", 32'(wvA), 32'h0);
      modelReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      clearLog();
      for (int i = 0; i < 16; i++) step(4'(i), 1'b1, 1'b0);
      chk("t5_count", winLog.size(), 4);
      chk("t5_win0", 32'(winLog[0]), 32'h14569);
      chk("t5_win3", 32'(winLog[3]), 32'h69ABE);
      chk("t5_fd", fdCnt, 1);

      // Random pixels, stalls and occasional sof
      for (int i = 0; i < 400; i++) begin
         bit v, s;
         v = ($urandom_range(0, 3) != 0);
         s = (i == 0) || ($urandom_range(0, 40) == 0);
         step(4'($urandom), v, s);
      end
      vldA = 1'b0;

      // 8x3 instance: pixel = col + 1
      useB = 1'b1;
      mW = 8; mH = 3;
      modelReset();
      clearLog();
      for (int i = 0; i < 24; i++) step(4'((i % 8) + 1), 1'b1, i == 0);
      step(4'h0, 1'b0, 1'b0);
      chk("t6_count", winLog.size(), 6);
      for (int k = 0; k < 6; k++) begin
         logic [3:0] cv;
         cv = 4'(k + 2);
         chk("t6_win", 32'(winLog[k]), 32'({cv, cv - 4'd1, cv, cv + 4'd1, cv}));
      end
      chk("t6_run", maxRun, 6);
      chk("t6_fd", fdCnt, 1);

      $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
      $finish;
   end

endmodule
